// File: rtl/bullet_fire_ctrl.sv
// bullet_fire_ctrl: rate-limited fire scheduler that hands each shot to the lowest free bullet slot.
// Optional hold-to-repeat fire is enabled by defining AUTOFIRE_EN.
module bullet_fire_ctrl #(
  parameter int N_SLOTS         = 4,
  parameter int COOLDOWN_FRAMES = 6,
  parameter int X_OFS           = 25,
  parameter int Y_OFS           = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               fire_btn,
  input  logic [9:0]         ship_x,
  input  logic [9:0]         ship_y,
  input  logic [N_SLOTS-1:0] slot_busy,
  output logic [N_SLOTS-1:0] launch,
  output logic [9:0]         launch_x,
  output logic [9:0]         launch_y,
  output logic               dry_fire,
  output logic               cooldown_active,
  output logic [7:0]         shots_fired
);
  typedef enum logic [1:0] {READY, LAUNCH, COOLDOWN} state_e;
  state_e             state_q;
  logic               btn_q, pending_q, rise, req;
  logic [7:0]         cnt_q;
  logic [N_SLOTS-1:0] free_slots, pick;
  assign rise = fire_btn & ~btn_q;
`ifdef AUTOFIRE_EN
  assign req = pending_q | rise | fire_btn;
`else
  assign req = pending_q | rise;
`endif
  assign free_slots = ~slot_busy;
  // isolate the lowest set bit: lowest-index free slot as a one-hot
  assign pick = free_slots & (~free_slots + N_SLOTS'(1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q         <= READY;
      btn_q           <= 1'b0;
      pending_q       <= 1'b0;
      cnt_q           <= '0;
      launch          <= '0;
      launch_x        <= '0;
      launch_y        <= '0;
      dry_fire        <= 1'b0;
      cooldown_active <= 1'b0;
      shots_fired     <= '0;
    end else begin
      btn_q     <= fire_btn;
      launch    <= '0;
      dry_fire  <= 1'b0;
      pending_q <= 1'b0;
      case (state_q)
        READY:
          if (frame_tick && req && free_slots != '0) begin
            state_q     <= LAUNCH;
            launch      <= pick;
            launch_x    <= ship_x + 10'(X_OFS);
            launch_y    <= ship_y + 10'(Y_OFS);
            shots_fired <= shots_fired + 8'd1;
          end else if (frame_tick && req) dry_fire <= 1'b1;
          else if (!frame_tick) pending_q <= pending_q | rise;
        LAUNCH: begin
          state_q         <= COOLDOWN_FRAMES == 0 ? READY : COOLDOWN;
          cnt_q           <= 8'(COOLDOWN_FRAMES);
          cooldown_active <= COOLDOWN_FRAMES != 0;
        end
        COOLDOWN:
          if (frame_tick) begin
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              state_q         <= READY;
              cooldown_active <= 1'b0;
            end
          end
        default: state_q <= READY;
      endcase
    end
endmodule

// File: tb/tb_bullet_fire_ctrl.sv
// tb_bullet_fire_ctrl: scenario and random checks of bullet_fire_ctrl against a frame-count reference model.
module tb_bullet_fire_ctrl;
  localparam int N = 4, CF = 6, XO = 25, YO = 14;
`ifdef AUTOFIRE_EN
  localparam bit AF = 1'b1;
`else
  localparam bit AF = 1'b0;
`endif
  logic clk = 0, rst_n = 0, frame_tick = 0, fire_btn = 0;
  logic [9:0] ship_x = 0, ship_y = 0;
  logic [N-1:0] slot_busy = 0, launch;
  logic [9:0] launch_x, launch_y;
  logic dry_fire, cooldown_active;
  logic [7:0] shots_fired;
  int n_chk = 0, n_fail = 0;
  bit m_prev, m_pend, m_lclk;
  int m_nt, m_next;
  logic [N-1:0] e_launch;
  logic e_dry, e_cool;
  logic [9:0] e_x, e_y;
  logic [7:0] e_shots;
  wire [N+29:0] obs  = {launch, dry_fire, cooldown_active, launch_x, launch_y, shots_fired};
  wire [N+29:0] expv = {e_launch, e_dry, e_cool, e_x, e_y, e_shots};

  bullet_fire_ctrl #(.N_SLOTS(N), .COOLDOWN_FRAMES(CF), .X_OFS(XO), .Y_OFS(YO)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .fire_btn(fire_btn),
    .ship_x(ship_x), .ship_y(ship_y), .slot_busy(slot_busy), .launch(launch),
    .launch_x(launch_x), .launch_y(launch_y), .dry_fire(dry_fire),
    .cooldown_active(cooldown_active), .shots_fired(shots_fired));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_prev = 0; m_pend = 0; m_lclk = 0; m_nt = 0; m_next = 0;
    e_launch = '0; e_dry = 0; e_cool = 0; e_x = '0; e_y = '0; e_shots = '0;
  endtask

  // launches are allowed on tick number >= m_next; m_nt counts ticks seen so far
  task automatic model_clk();
    bit rise, req;
    int f;
    rise = fire_btn && !m_prev;
    m_prev = fire_btn;
    e_launch = '0;
    e_dry = 0;
    if (!m_lclk && m_nt >= m_next) begin
      req = m_pend || rise || (AF && fire_btn);
      if (frame_tick) begin
        m_pend = 0;
        if (req) begin
          f = -1;
          for (int i = N - 1; i >= 0; i--) if (!slot_busy[i]) f = i;
          if (f < 0) e_dry = 1;
          else begin
            e_launch[f] = 1'b1;
            e_x = 10'((int'(ship_x) + XO) % 1024);
            e_y = 10'((int'(ship_y) + YO) % 1024);
            e_shots = e_shots + 8'd1;
            m_next = m_nt + CF + 1;
          end
        end
      end else m_pend = m_pend || rise;
    end else m_pend = 0;
    if (frame_tick) m_nt++;
    m_lclk = e_launch != '0;
    e_cool = !m_lclk && m_nt < m_next;
  endtask

  task automatic step(input bit t, input bit b);
    frame_tick = t;
    fire_btn = b;
    model_clk();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic frame(input bit b1, input bit b2);
    step(0, b1);
    step(1, b2);
  endtask

  task automatic do_reset();
    frame_tick = 0;
    fire_btn = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    ship_x = 10'(333); ship_y = 10'(444); fire_btn = 1;
    @(negedge clk);
    n_chk++; if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h exp 0", obs); end
    fire_btn = 0; rst_n = 1; model_reset();
    step(0, 0);
    n_chk++; if (obs !== expv) begin n_fail++; $display("FAIL reset_idle: got %h exp %h", obs, expv); end
    ship_x = 10'(100); ship_y = 10'(200); slot_busy = '0;
    step(0, 1);
    frame_tick = 1; fire_btn = 0; model_clk();
    @(posedge clk);
    #1;
    n_chk++; if (obs !== expv || launch !== 4'b0001) begin n_fail++; $display("FAIL reset_prelaunch: got %h exp %h", obs, expv); end
    #2 rst_n = 0;
    #1;
    n_chk++; if (obs !== '0) begin n_fail++; $display("FAIL reset_midlaunch: got %h exp 0", obs); end
    frame_tick = 0;
    @(negedge clk);
    rst_n = 1; model_reset();
    step(0, 0);
    n_chk++; if (obs !== expv) begin n_fail++; $display("FAIL reset_release: got %h exp %h", obs, expv); end
    step(1, 0);
    n_chk++; if (obs !== expv || launch !== '0) begin n_fail++; $display("FAIL reset_nopulse: got %h exp %h", obs, expv); end
  endtask

  task automatic test_single_shot();
    do_reset();
    ship_x = 10'(100); ship_y = 10'(200); slot_busy = '0;
    frame(1, 0);
    n_chk++; if (obs !== expv) begin n_fail++; $display("FAIL single_model: got %h exp %h", obs, expv); end
    n_chk++; if ({launch, launch_x, launch_y, shots_fired} !== {4'b0001, 10'd125, 10'd214, 8'd1}) begin
      n_fail++; $display("FAIL single_values: got %b %0d %0d %0d exp 0001 125 214 1", launch, launch_x, launch_y, shots_fired); end
    step(0, 0);
    n_chk++; if (obs !== expv || launch !== '0 || cooldown_active !== 1'b1) begin n_fail++; $display("FAIL single_after: got %h exp %h", obs, expv); end
  endtask

  task automatic test_cooldown();
    do_reset();
    slot_busy = '0;
    frame(1, 0);
    for (int i = 1; i <= 7; i++) begin
      frame(i == 3 || i == 7, 0);
      n_chk++; if (obs !== expv) begin n_fail++; $display("FAIL cooldown_model f%0d: got %h exp %h", i, obs, expv); end
      if (i == 3) begin
        n_chk++; if (launch !== '0) begin n_fail++; $display("FAIL cooldown_blocked: got %b exp 0000", launch); end
      end
    end
    n_chk++; if (launch === '0 || shots_fired !== 8'd2) begin n_fail++; $display("FAIL cooldown_relaunch: got %b shots %0d exp launch shots 2", launch, shots_fired); end
  endtask

  task automatic test_alloc();
    do_reset();
    slot_busy = 4'b0101;
    frame(1, 0);
    n_chk++; if (obs !== expv || launch !== 4'b0010) begin n_fail++; $display("FAIL alloc_lowest: got %b exp 0010", launch); end
    repeat (7) frame(0, 0);
    slot_busy = 4'b1111;
    frame(1, 0);
    n_chk++; if (obs !== expv || dry_fire !== 1'b1 || launch !== '0) begin n_fail++; $display("FAIL alloc_dry: got dry %b launch %b exp 1 0000", dry_fire, launch); end
    step(0, 0);
    n_chk++; if (obs !== expv || dry_fire !== 1'b0) begin n_fail++; $display("FAIL alloc_dry_pulse: got %b exp 0", dry_fire); end
  endtask

  task automatic test_wrap();
    do_reset();
    ship_x = 10'(1010); ship_y = 10'(1020); slot_busy = '0;
    for (int i = 0; i < 256; i++) begin
      frame(1, 0);
      n_chk++; if (obs !== expv) begin n_fail++; $display("FAIL wrap_model %0d: got %h exp %h", i, obs, expv); end
      if (i == 0) begin
        n_chk++; if (launch_x !== 10'd11 || launch_y !== 10'd10) begin n_fail++; $display("FAIL wrap_pos: got %0d %0d exp 11 10", launch_x, launch_y); end
      end
      repeat (6) frame(0, 0);
    end
    n_chk++; if (shots_fired !== 8'd0) begin n_fail++; $display("FAIL wrap_count: got %0d exp 0", shots_fired); end
  endtask

  task automatic test_autofire();
    int nl = 0;
    do_reset();
    slot_busy = '0;
    for (int i = 0; i < 20; i++) begin
      frame(1, 1);
      n_chk++; if (obs !== expv) begin n_fail++; $display("FAIL autofire_model f%0d: got %h exp %h", i, obs, expv); end
      if (launch !== '0) nl++;
    end
    n_chk++; if (nl != (AF ? 3 : 1)) begin n_fail++; $display("FAIL autofire_count: got %0d exp %0d", nl, AF ? 3 : 1); end
    fire_btn = 0;
  endtask

  task automatic test_random();
    bit pt = 0, t, b = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      t = !pt && $urandom_range(3) == 0;
      if ($urandom_range(2) == 0) b = !b;
      if ($urandom_range(7) == 0) slot_busy = $urandom_range(3) == 0 ? '1 : N'($urandom);
      if ($urandom_range(15) == 0) begin ship_x = 10'($urandom); ship_y = 10'($urandom); end
      step(t, b);
      pt = t;
      n_chk++; if (obs !== expv) begin n_fail++; $display("FAIL random_model c%0d: got %h exp %h", i, obs, expv); end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_single_shot();
    test_cooldown();
    test_alloc();
    test_wrap();
    test_autofire();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
